// File: rtl/multiplier_ctrl.sv
// Sequencing controller for the byte-sliced RV32M multiplier datapath: one load cycle,
// four rotate/partial-product cycles, optional accumulate drain, then a one-cycle done.
module multiplier_ctrl #(
    parameter int unsigned PIPE = 32'd1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic [1:0] funct3_i,
    input  logic       kill_i,
    output logic       ready_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       hi_sel_o,
    output logic       reg_A_en_o,
    output logic       reg_B_en_o,
    output logic       mux_B_sel_o,
    output logic       rol_en_o,
    output logic       signed_A_o,
    output logic [3:0] sig_ctrl_B_o,
    output logic [2:0] shift_0_o,
    output logic [2:0] shift_1_o,
    output logic [2:0] shift_2_o,
    output logic [2:0] shift_3_o,
    output logic       AC_en_o,
    output logic       acc_clr_o
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_CALC  = 3'd2;
    localparam logic [2:0] ST_DRAIN = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [1:0]       step_q, step_d;
    logic [1:0]       op_q, op_d;
    logic             hi_sel_q, hi_sel_d;

    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             reg_a_en_q, reg_a_en_d;
    logic             reg_b_en_q, reg_b_en_d;
    logic             mux_b_sel_q, mux_b_sel_d;
    logic             rol_en_q, rol_en_d;
    logic             signed_a_q, signed_a_d;
    logic [3:0]       sig_ctrl_b_q, sig_ctrl_b_d;
    logic [3:0][2:0]  shift_q, shift_d;
    logic             ac_en_q, ac_en_d;
    logic             acc_clr_q, acc_clr_d;

    logic             acc_vld_s;
    logic [1:0]       acc_step_s;

    // Slot i multiplies A byte i by original B byte (i - step) mod 4.
    function automatic logic [2:0] slot_shift(input logic [1:0] slot, input logic [1:0] step);
        logic [1:0] byte_j;
        byte_j = slot - step;
        return {1'b0, slot} + {1'b0, byte_j};
    endfunction

    function automatic logic [3:0] sign_slot(input logic [1:0] step);
        logic [3:0] vec;
        logic [1:0] slot;
        vec       = 4'b0000;
        slot      = step + 2'd3;
        vec[slot] = 1'b1;
        return vec;
    endfunction

    function automatic logic op_signed_a(input logic [1:0] op);
        return (op == 2'b01) || (op == 2'b10);
    endfunction

    function automatic logic op_signed_b(input logic [1:0] op);
        return (op == 2'b01);
    endfunction

    // Sequencer next state, operation capture and result word select.
    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        op_d     = op_q;
        hi_sel_d = hi_sel_q;
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d  = ST_LOAD;
                    step_d   = 2'd0;
                    op_d     = funct3_i;
                    hi_sel_d = (funct3_i != 2'b00);
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_CALC;
                step_d  = 2'd0;
            end
            ST_CALC: begin
                if (step_q == 2'd3) begin
                    state_d = (PIPE != 32'd0) ? ST_DRAIN : ST_DONE;
                    step_d  = 2'd0;
                end else begin
                    step_d  = step_q + 2'd1;
                end
            end
            ST_DRAIN: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default: begin
                state_d = ST_IDLE;
                step_d  = 2'd0;
            end
        endcase
        if (kill_i && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            step_d  = 2'd0;
        end else begin
            state_d = state_d;
        end
    end

    if (PIPE == 32'd0) begin : g_no_pipe
        // Accumulate controls follow the partial-product step being issued.
        always_comb begin
            acc_vld_s  = (state_d == ST_CALC);
            acc_step_s = step_d;
        end
    end else begin : g_pipe
        // Accumulate controls trail one cycle behind; kill flushes the pending step.
        always_comb begin
            acc_vld_s  = (state_q == ST_CALC) && !kill_i;
            acc_step_s = step_q;
        end
    end

    // Moore decode of the upcoming cycle, registered into the output flops.
    always_comb begin
        ready_d     = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        done_d      = (state_d == ST_DONE);
        reg_a_en_d  = (state_d == ST_LOAD);
        reg_b_en_d  = (state_d == ST_LOAD) || (state_d == ST_CALC);
        mux_b_sel_d = (state_d == ST_CALC);
        rol_en_d    = (state_d == ST_CALC);
        signed_a_d  = busy_d && op_signed_a(op_d);
        if ((state_d == ST_CALC) && op_signed_b(op_d)) begin
            sig_ctrl_b_d = sign_slot(step_d);
        end else begin
            sig_ctrl_b_d = 4'b0000;
        end
        ac_en_d   = acc_vld_s;
        acc_clr_d = acc_vld_s && (acc_step_s == 2'd0);
        for (int i = 0; i < 4; i++) begin
            shift_d[i] = acc_vld_s ? slot_shift(2'(i), acc_step_s) : 3'd0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_IDLE;
            step_q       <= 2'd0;
            op_q         <= 2'b00;
            hi_sel_q     <= 1'b0;
            ready_q      <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            reg_a_en_q   <= 1'b0;
            reg_b_en_q   <= 1'b0;
            mux_b_sel_q  <= 1'b0;
            rol_en_q     <= 1'b0;
            signed_a_q   <= 1'b0;
            sig_ctrl_b_q <= 4'b0000;
            shift_q      <= '0;
            ac_en_q      <= 1'b0;
            acc_clr_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            op_q         <= op_d;
            hi_sel_q     <= hi_sel_d;
            ready_q      <= ready_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            reg_a_en_q   <= reg_a_en_d;
            reg_b_en_q   <= reg_b_en_d;
            mux_b_sel_q  <= mux_b_sel_d;
            rol_en_q     <= rol_en_d;
            signed_a_q   <= signed_a_d;
            sig_ctrl_b_q <= sig_ctrl_b_d;
            shift_q      <= shift_d;
            ac_en_q      <= ac_en_d;
            acc_clr_q    <= acc_clr_d;
        end
    end

    assign ready_o      = ready_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign hi_sel_o     = hi_sel_q;
    assign reg_A_en_o   = reg_a_en_q;
    assign reg_B_en_o   = reg_b_en_q;
    assign mux_B_sel_o  = mux_b_sel_q;
    assign rol_en_o     = rol_en_q;
    assign signed_A_o   = signed_a_q;
    assign sig_ctrl_B_o = sig_ctrl_b_q;
    assign shift_0_o    = shift_q[0];
    assign shift_1_o    = shift_q[1];
    assign shift_2_o    = shift_q[2];
    assign shift_3_o    = shift_q[3];
    assign AC_en_o      = ac_en_q;
    assign acc_clr_o    = acc_clr_q;

endmodule

// File: doc/multiplier_ctrl.md
# multiplier_ctrl

Sequencing controller for the byte-sliced RV32M multiplier datapath. It accepts one multiply request at a time and captures the operation type. It then drives the datapath's register enables, operand-B rotate/mux selects, sign-extension and shift controls, and accumulator enables over one load cycle and four partial-product cycles. Completion is signalled with a one-cycle done pulse. It sits between the RV32M decode/issue logic and the multiplier datapath.

## Interface
- PIPE, 1: pipeline registers between the byte multipliers and the accumulator (0 or 1); delays all accumulate-side controls by PIPE cycles.

- clk_i  input  1  clock; all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request; accepted only when ready_o=1
- funct3_i  input  2  op select, low two bits of RV32M funct3 (00 MUL, 01 MULH, 10 MULHSU, 11 MULHU); sampled with accepted start
- kill_i  input  1  synchronous abort of the operation in flight
- ready_o  output  1  controller idle, start accepted this cycle
- busy_o  output  1  operation in flight
- done_o  output  1  one-cycle pulse: accumulator holds the final 64-bit product
- hi_sel_o  output  1  result word select (1 = upper 32 bits), held from accept until next accept
- reg_A_en_o, reg_B_en_o  output  1 each  datapath operand register enables
- mux_B_sel_o  output  1  0 = op_B input, 1 = recirculate reg B
- rol_en_o  output  1  rotate B left by one byte
- signed_A_o  output  1  sign-extend A byte 3
- sig_ctrl_B_o  output  4  per-slot sign extension of the current B byte
- shift_0_o..shift_3_o  output  3 each  byte-shift of each slice product into the accumulator
- AC_en_o  output  1  accumulator enable
- acc_clr_o  output  1  accumulator loads instead of adding (first partial-product cycle)

## Operation
- Reset values: ready_o=1, all other outputs 0, internal step counter 0, captured op = 00.
- States: IDLE, LOAD, CALC (step k=0..3), DRAIN (only when PIPE=1), DONE.
- IDLE -> LOAD on start_i. funct3 is captured; start_i in any other state is ignored.
- LOAD: reg_A_en=reg_B_en=1, mux_B_sel=0, rol_en=0. Next state is CALC with k=0.
- CALC k: reg_B_en=1, mux_B_sel=1, rol_en=1, so B rotates one byte at each edge. After k=3 the rotation returns B to its original alignment. k=3 exits to DRAIN if PIPE=1, otherwise to DONE.
- Slot i in step k holds original B byte j=(i-k) mod 4.
  - shift_i = i + j (range 0..6).
  - sig_ctrl_B bit i = signed_B and (i == (3+k) mod 4).
- Signedness by captured op:
  - 00: A unsigned, B unsigned, hi_sel 0.
  - 01: A signed, B signed, hi_sel 1.
  - 10: A signed, B unsigned, hi_sel 1.
  - 11: A unsigned, B unsigned, hi_sel 1.
  - signed_A_o is held from LOAD through DONE.
- Accumulate-side signals (AC_en_o, acc_clr_o, shift_*_o) for step k are asserted PIPE cycles after CALC k. acc_clr_o accompanies step 0 only. sig_ctrl_B_o is not delayed.
- DRAIN (PIPE=1): no register enables; carries the delayed step-3 accumulate controls.
- DONE: done_o=1 for one cycle, then IDLE.
- busy_o=1 in LOAD, CALC, DRAIN and DONE.
- kill_i in any non-IDLE state: next state is IDLE. All enables are 0 from the following cycle, no done_o, and pending delayed accumulate controls are flushed. kill_i with start_i in IDLE: start is accepted and kill is ignored.
- rst_i mid-operation: same as kill, and all outputs take their reset values.

## Timing
- Start accepted at edge T. LOAD occupies cycle T+1, CALC occupies T+2..T+5, DRAIN occupies T+6 (PIPE=1).
- done_o is asserted in cycle T+6+PIPE. ready_o is 1 again in cycle T+7+PIPE.
- Issue rate: one operation per 7+PIPE cycles. Back-to-back start_i is accepted on the first ready cycle.
- All outputs are Moore-decoded from registered state plus the PIPE delay line. There are no combinational paths from start_i, funct3_i or kill_i to any output.

## Test plan
- Reset then idle: rst_i held 2 cycles -> all outputs 0 except ready_o=1. No activity with start_i=0.
- MULHU, PIPE=0: start at T -> reg_A_en/reg_B_en high in T+1 only; rol_en high T+2..T+5; AC_en high T+2..T+5 with acc_clr only at T+2; shifts (step0) 0,2,4,6, (step1) 3,1,3,5, (step2) 2,4,2,4, (step3) 1,3,5,3; sig_ctrl_B=0; done_o at T+6; hi_sel_o=1.
- MULH, PIPE=1: sig_ctrl_B = 1000,0001,0010,0100 in T+2..T+5; AC_en in T+3..T+6; signed_A_o=1; done_o at T+7. Datapath co-sim of 0x80000000 x 0xFFFFFFFF gives upper word 0x00000000, full product 0x0000000080000000.
- MULHSU/MUL signedness: op 10 -> signed_A=1, sig_ctrl_B=0; op 00 -> both 0, hi_sel 0. Random co-sim against a reference 64-bit product for all four ops (1000 vectors each).
- Kill at T+3 -> no done_o; AC_en=0 from T+4 (including delayed PIPE controls); ready_o=1 at T+4; a new start immediately after completes normally.
- Start held high continuously -> operations accepted every 7+PIPE cycles, exactly one done_o per operation. start_i pulses while busy are ignored.
